// File: rtl/stage_ctrl_if.sv
// Command-stream handshake for stage_ctrl: 32-bit beats with valid/last
// from the control plane, ready back from the stage sequencer.
interface stage_ctrl_if;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic        ctrl_last;
  logic        ctrl_ready;

  modport master (output ctrl_data, ctrl_valid, ctrl_last, input ctrl_ready);
  modport slave  (input ctrl_data, ctrl_valid, ctrl_last, output ctrl_ready);
endinterface

// File: rtl/stage_ctrl.sv
// Per-stage configuration sequencer: filters commands by stage ID, deserialises payload
// beats and strobes key-offset / lookup / action table writes. Stats gated by STAGE_CTRL_STATS_EN.
module stage_ctrl #(
  parameter int unsigned STAGE   = 0,
  parameter int unsigned KEY_LEN = 197,
  parameter int unsigned ACT_LEN = 25,
  parameter int unsigned KEY_OFF = 18,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                   axis_clk,
  input  logic                   aresetn,
  stage_ctrl_if.slave            ctrl,
  output logic [KEY_OFF-1:0]     key_offset_out,
  output logic                   key_offset_valid_out,
  output logic [KEY_LEN-1:0]     lookup_din,
  output logic [KEY_LEN-1:0]     lookup_din_mask,
  output logic [ADDR_W-1:0]      lookup_din_addr,
  output logic                   lookup_din_en,
  output logic [ACT_LEN*25-1:0]  action_data_in,
  output logic [ADDR_W-1:0]      action_addr,
  output logic                   action_en,
  output logic [15:0]            cfg_ok_cnt,
  output logic [15:0]            cfg_err_cnt
);

  // The action word is the widest payload, so it sizes the assembly register.
  localparam int unsigned ACT_W    = ACT_LEN * 25;
  localparam logic [4:0]  REQ_KOFF = 5'((KEY_OFF + 31) / 32);
  localparam logic [4:0]  REQ_LKUP = 5'((2 * KEY_LEN + 31) / 32);
  localparam logic [4:0]  REQ_ACT  = 5'((ACT_W + 31) / 32);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD, S_WRITE} state_e;
  typedef enum logic [1:0] {T_KOFF = 2'd0, T_LKUP = 2'd1, T_ACT = 2'd2, T_RSVD = 2'd3} tgt_e;

  state_e              state_q, state_d;
  tgt_e                tgt_q;
  tgt_e                hdr_tgt;
  logic [ADDR_W-1:0]   addr_q;
  logic [4:0]          cnt_q, cnt_inc, req_cnt;
  logic [ACT_W-1:0]    asm_q, asm_nxt;
  logic                ready_en_q;
  logic                fire, hdr_fire, beat_fire, hdr_hit, hdr_take, enough, wr_load;

  assign ctrl.ctrl_ready = ready_en_q && (state_q != S_WRITE);
  assign fire      = ctrl.ctrl_valid && ctrl.ctrl_ready;
  assign hdr_fire  = fire && (state_q == S_IDLE);
  assign beat_fire = fire && (state_q == S_COLLECT);
  assign hdr_hit   = (ctrl.ctrl_data[31:28] == 4'(STAGE));
  assign hdr_tgt   = tgt_e'(ctrl.ctrl_data[27:26]);
  assign hdr_take  = hdr_fire && hdr_hit && (hdr_tgt != T_RSVD) && !ctrl.ctrl_last;

  always_comb begin
    req_cnt = REQ_ACT;
    case (tgt_q)
      T_KOFF:  req_cnt = REQ_KOFF;
      T_LKUP:  req_cnt = REQ_LKUP;
      default: req_cnt = REQ_ACT;
    endcase
  end

  // Beats past the required count leave the assembly untouched; the count saturates.
  always_comb begin
    cnt_inc = cnt_q;
    asm_nxt = asm_q;
    if (cnt_q < req_cnt) begin
      cnt_inc = cnt_q + 5'd1;
      asm_nxt = asm_q | (ACT_W'(ctrl.ctrl_data) << {cnt_q, 5'b00000});
    end
  end

  assign enough  = (cnt_inc >= req_cnt);
  assign wr_load = beat_fire && ctrl.ctrl_last && enough;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (!hdr_hit || hdr_tgt == T_RSVD)
            state_d = ctrl.ctrl_last ? S_IDLE : S_DISCARD;
          else if (!ctrl.ctrl_last)
            state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (fire && ctrl.ctrl_last)
          state_d = enough ? S_WRITE : S_IDLE;
      end
      S_DISCARD: begin
        if (fire && ctrl.ctrl_last)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      tgt_q  <= T_KOFF;
      addr_q <= '0;
      cnt_q  <= '0;
      asm_q  <= '0;
    end else if (hdr_take) begin
      tgt_q  <= hdr_tgt;
      addr_q <= ctrl.ctrl_data[ADDR_W-1:0];
      cnt_q  <= '0;
      asm_q  <= '0;
    end else if (beat_fire) begin
      cnt_q  <= cnt_inc;
      asm_q  <= asm_nxt;
    end
  end

  // Output words load alongside the final beat so they are valid during the WRITE strobe.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      key_offset_out  <= '0;
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      action_data_in  <= '0;
      action_addr     <= '0;
    end else if (wr_load) begin
      case (tgt_q)
        T_KOFF: key_offset_out <= asm_nxt[KEY_OFF-1:0];
        T_LKUP: begin
          lookup_din      <= asm_nxt[KEY_LEN-1:0];
          lookup_din_mask <= asm_nxt[2*KEY_LEN-1:KEY_LEN];
          lookup_din_addr <= addr_q;
        end
        default: begin
          action_data_in <= asm_nxt;
          action_addr    <= addr_q;
        end
      endcase
    end
  end

  always_comb begin
    key_offset_valid_out = 1'b0;
    lookup_din_en        = 1'b0;
    action_en            = 1'b0;
    if (state_q == S_WRITE) begin
      case (tgt_q)
        T_KOFF:  key_offset_valid_out = 1'b1;
        T_LKUP:  lookup_din_en        = 1'b1;
        default: action_en            = 1'b1;
      endcase
    end
  end

`ifdef STAGE_CTRL_STATS_EN
  logic err_evt;

  assign err_evt = (hdr_fire && hdr_hit && (hdr_tgt == T_RSVD || ctrl.ctrl_last)) ||
                   (beat_fire && ctrl.ctrl_last && !enough);

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_ok_cnt  <= '0;
      cfg_err_cnt <= '0;
    end else begin
      if (state_q == S_WRITE && cfg_ok_cnt != '1)
        cfg_ok_cnt <= cfg_ok_cnt + 16'd1;
      if (err_evt && cfg_err_cnt != '1)
        cfg_err_cnt <= cfg_err_cnt + 16'd1;
    end
  end
`else
  assign cfg_ok_cnt  = '0;
  assign cfg_err_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// Scoreboard bench for stage_ctrl: directed test-plan commands plus random traffic,
// expected writes derived from the command rules and checked by an independent monitor.
module tb_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_ctrl_if ifc();

  logic [17:0]  key_offset_out;
  logic         key_offset_valid_out;
  logic [196:0] lookup_din, lookup_din_mask;
  logic [3:0]   lookup_din_addr, action_addr;
  logic         lookup_din_en, action_en;
  logic [624:0] action_data_in;
  logic [15:0]  cfg_ok_cnt, cfg_err_cnt;

  stage_ctrl #(.STAGE(0), .KEY_LEN(197), .ACT_LEN(25), .KEY_OFF(18), .ADDR_W(4)) dut (
    .axis_clk             (clk),
    .aresetn              (rst_n),
    .ctrl                 (ifc),
    .key_offset_out       (key_offset_out),
    .key_offset_valid_out (key_offset_valid_out),
    .lookup_din           (lookup_din),
    .lookup_din_mask      (lookup_din_mask),
    .lookup_din_addr      (lookup_din_addr),
    .lookup_din_en        (lookup_din_en),
    .action_data_in       (action_data_in),
    .action_addr          (action_addr),
    .action_en            (action_en),
    .cfg_ok_cnt           (cfg_ok_cnt),
    .cfg_err_cnt          (cfg_err_cnt)
  );

  typedef struct {
    int          tgt;
    logic [3:0]  addr;
    logic [639:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_ok = 0;
  int          m_err = 0;
  logic [31:0] pl[0:31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [639:0] got, input logic [639:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int req_beats(input int tgt);
    case (tgt)
      0: return 1;
      1: return 13;
      default: return 20;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest expected write, with no overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = int'(key_offset_valid_out) + int'(lookup_din_en) + int'(action_en);
      if (n > 1) chk("one_hot_strobe", 640'(n), 640'd1);
      if (n != 0) begin
        chk("ready_low_in_write", 640'(ifc.ctrl_ready), 640'd0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 640'(n), 640'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_cycle", 640'(cyc), 640'(e.cyc));
          case (e.tgt)
            0: begin
              chk("koff_strobe", 640'(key_offset_valid_out), 640'd1);
              chk("koff_data", 640'(key_offset_out), 640'(e.data[17:0]));
            end
            1: begin
              chk("lkup_strobe", 640'(lookup_din_en), 640'd1);
              chk("lkup_key", 640'(lookup_din), 640'(e.data[196:0]));
              chk("lkup_mask", 640'(lookup_din_mask), 640'(e.data[393:197]));
              chk("lkup_addr", 640'(lookup_din_addr), 640'(e.addr));
            end
            default: begin
              chk("act_strobe", 640'(action_en), 640'd1);
              chk("act_data", 640'(action_data_in), 640'(e.data[624:0]));
              chk("act_addr", 640'(action_addr), 640'(e.addr));
            end
          endcase
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int tries;
    logic acc;
    if ($urandom_range(0, 3) == 0) begin
      ifc.ctrl_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    ifc.ctrl_data  = d;
    ifc.ctrl_last  = last;
    ifc.ctrl_valid = 1'b1;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 40) begin
      @(negedge clk);
      acc = ifc.ctrl_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) chk("beat_accept_timeout", 640'(tries), 640'd0);
  endtask

  // Reference: header rules decide the outcome; beats are packed LSB-first.
  task automatic send_cmd(input logic [31:0] hdr, input int n);
    int tgt;
    bit hit;
    exp_t e;
    tgt = int'(hdr[27:26]);
    hit = (hdr[31:28] == 4'd0);
    send_beat(hdr, n == 0);
    for (int i = 0; i < n; i++) send_beat(pl[i], i == n - 1);
    ifc.ctrl_valid = 1'b0;
    ifc.ctrl_last  = 1'b0;
    if (!hit) return;
    if (tgt == 3 || n == 0 || n < req_beats(tgt)) begin
      m_err++;
      return;
    end
    e.tgt  = tgt;
    e.addr = hdr[3:0];
    e.data = '0;
    for (int i = 0; i < req_beats(tgt); i++) e.data[32*i +: 32] = pl[i];
    e.cyc  = cyc;
    sb.push_back(e);
    m_ok++;
  endtask

  task automatic chk_stats(input string tag);
    repeat (2) @(posedge clk);
    #1;
`ifdef STAGE_CTRL_STATS_EN
    chk({tag, "_ok_cnt"}, 640'(cfg_ok_cnt), 640'(m_ok));
    chk({tag, "_err_cnt"}, 640'(cfg_err_cnt), 640'(m_err));
`else
    chk({tag, "_ok_cnt"}, 640'(cfg_ok_cnt), 640'd0);
    chk({tag, "_err_cnt"}, 640'(cfg_err_cnt), 640'd0);
`endif
    chk({tag, "_drained"}, 640'(sb.size()), 640'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 640'(ifc.ctrl_ready), 640'd0);
    chk({tag, "_strobes"}, 640'({key_offset_valid_out, lookup_din_en, action_en}), 640'd0);
    chk({tag, "_koff"}, 640'(key_offset_out), 640'd0);
    chk({tag, "_lkup"}, 640'({lookup_din, lookup_din_mask, lookup_din_addr}), 640'd0);
    chk({tag, "_act"}, 640'({action_addr, action_data_in}), 640'd0);
    chk({tag, "_stats"}, 640'({cfg_ok_cnt, cfg_err_cnt}), 640'd0);
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, tgt, r;
    logic [31:0] hdr;
    ifc.ctrl_data  = '0;
    ifc.ctrl_valid = 1'b0;
    ifc.ctrl_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", 640'(ifc.ctrl_ready), 640'd0);
    @(posedge clk);
    #1;
    chk("ready_after_release", 640'(ifc.ctrl_ready), 640'd1);

    pl[0] = 32'h0002_ABCD;
    send_cmd(32'h0000_0000, 1);
    chk_stats("koff");

    for (int i = 0; i < 13; i++) pl[i] = 32'(i + 1);
    send_cmd(32'h0400_0005, 13);
    chk_stats("lookup");

    for (int i = 0; i < 20; i++) pl[i] = 32'hFFFF_FFFF;
    send_cmd(32'h0800_000F, 20);
    chk_stats("action");

    for (int i = 0; i < 13; i++) pl[i] = $urandom;
    send_cmd(32'h1400_0000, 13);
    chk_stats("mismatch");

    send_cmd(32'h0400_0003, 5);
    chk_stats("short");
    pl[0] = 32'h1234_5678;
    send_cmd(32'h0000_0000, 1);
    chk_stats("after_short");

    send_cmd(32'h0C00_0001, 0);
    send_cmd(32'h0400_0002, 0);
    chk_stats("hdr_errors");

    // Reset while an action command is half-assembled.
    send_beat(32'h0800_0007, 1'b0);
    for (int i = 0; i < 10; i++) send_beat($urandom, 1'b0);
    ifc.ctrl_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    m_ok = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    chk_zero("midreset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) pl[i] = $urandom;
    send_cmd(32'h0800_0009, 20);
    chk_stats("post_reset");

    for (int k = 0; k < 40; k++) begin
      hdr = $urandom;
      if ($urandom_range(0, 4) != 0) hdr[31:28] = 4'd0;
      tgt = int'(hdr[27:26]);
      r = $urandom_range(0, 9);
      if (tgt == 3) n = $urandom_range(0, 5);
      else if (r == 0) n = 0;
      else if (r <= 2) n = (req_beats(tgt) > 1) ? $urandom_range(1, req_beats(tgt) - 1) : 0;
      else if (r <= 8) n = req_beats(tgt);
      else n = req_beats(tgt) + $urandom_range(1, 3);
      for (int i = 0; i < 32; i++) pl[i] = $urandom;
      send_cmd(hdr, n);
      if ($urandom_range(0, 2) == 0) chk_stats("rand");
    end
    chk_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Control-plane sequencer for one RMT pipeline stage. It accepts a 32-bit command stream (header word plus payload beats) and filters commands by stage ID. It deserialises the payload into full-width words and issues single-cycle write strobes to three tables: the stage's key-extractor offset RAM, the lookup key/mask table, and the action RAM. One instance sits beside each stage and drives that stage's currently unconnected configuration ports.

## Interface
- STAGE, 0, stage ID this instance answers to (0-4)
- KEY_LEN, 197, lookup key width
- ACT_LEN, 25, single action width; action RAM word is ACT_LEN*25 = 625 bits
- KEY_OFF, 18, key-extractor offset word width
- ADDR_W, 4, table address width (lookup and action)
- axis_clk  in  1  clock, sole clock domain
- aresetn  in  1  asynchronous active-low reset
- ctrl_data  in  32  command beat
- ctrl_valid  in  1  beat valid
- ctrl_last  in  1  final beat of the command
- ctrl_ready  out  1  beat accepted when ctrl_valid && ctrl_ready
- key_offset_out  out  KEY_OFF  offset word to key extractor
- key_offset_valid_out  out  1  one-cycle write strobe
- lookup_din  out  KEY_LEN  key entry
- lookup_din_mask  out  KEY_LEN  mask entry
- lookup_din_addr  out  ADDR_W  entry address
- lookup_din_en  out  1  one-cycle write strobe
- action_data_in  out  625  action word
- action_addr  out  ADDR_W  action address
- action_en  out  1  one-cycle write strobe
- cfg_ok_cnt  out  16  completed writes (stats)
- cfg_err_cnt  out  16  malformed commands (stats)

## Operation
- Header beat fields:
  - [31:28] stage ID
  - [27:26] target: 0 = key offset, 1 = lookup, 2 = action, 3 = reserved
  - [ADDR_W-1:0] address
  - all other bits ignored
- Payload is packed LSB-first: beat i fills assembled bits [32i+31:32i].
- Required payload beats:
  - key offset: 1; uses bits [KEY_OFF-1:0]
  - lookup: 13; key = [KEY_LEN-1:0], mask = [2*KEY_LEN-1:KEY_LEN]
  - action: 20; uses bits [624:0]
- Beat counter is 5 bits and saturates at the required count. Beats beyond the required count are accepted and ignored.
- FSM:
  - IDLE: the accepted beat is the header.
    - Stage ID ≠ STAGE: go to DISCARD, or stay in IDLE if ctrl_last. Not an error.
    - Target 3: error; go to DISCARD, or stay in IDLE if ctrl_last.
    - Header carrying ctrl_last: error; stay in IDLE.
    - Otherwise latch target and address, clear the assembly register, go to COLLECT.
  - COLLECT: shift in beats. On ctrl_last:
    - count ≥ required: go to WRITE.
    - count < required: error, no write, go to IDLE.
  - DISCARD: consume beats until ctrl_last, then go to IDLE.
  - WRITE: drive the target's data/address outputs and pulse its strobe for exactly one cycle, then go to IDLE.
- ctrl_ready = 1 in IDLE, COLLECT and DISCARD; 0 in WRITE.
- Data/address outputs hold their last written value between writes. Only one strobe is ever high in any cycle.
- Counter updates:
  - cfg_ok_cnt increments in WRITE.
  - cfg_err_cnt increments on each error event.
  - Both saturate at 0xFFFF.

## Timing
- Reset (asynchronous, any state):
  - FSM to IDLE
  - all outputs 0, except ctrl_ready = 1 one cycle after deassertion
  - assembly register, beat counter and stats cleared
  - an in-flight command is dropped with no strobe
- Last payload beat accepted in cycle N:
  - strobe high and ctrl_ready low in cycle N+1
  - next header acceptable in cycle N+2
- Lookup write spans 15 cycles minimum: 14 beats plus the WRITE cycle.
- Data and address are valid in the same cycle as the strobe.
- ctrl_valid low mid-command stalls the FSM with no timeout. State and count are held.

## Configuration
- STAGE_CTRL_STATS_EN defined: cfg_ok_cnt and cfg_err_cnt are implemented as specified.
- Not defined: both outputs are tied to 0, no counter flops are built, and all other behaviour is unchanged.

## Test plan
- Key-offset write:
  - stimulus: header 0x0000_0000 (STAGE = 0, target 0), then payload 0x0002_ABCD with last.
  - response: key_offset_out = 18'h2ABCD, key_offset_valid_out high for one cycle, one cycle after the payload beat.
- Lookup write:
  - stimulus: header 0x0400_0005, then 13 beats, beat i = i+1, last on beat 13.
  - response: lookup_din_addr = 5; lookup_din bits [31:0] = 1; mask taken from assembled bits [393:197]; one lookup_din_en pulse; ctrl_ready low for that cycle.
- Action write:
  - stimulus: header 0x0800_000F, then 20 beats of 0xFFFF_FFFF.
  - response: action_addr = 15, action_data_in all ones, action_en pulse, cfg_ok_cnt = 1.
- Stage mismatch:
  - stimulus: header 0x1400_0000, then 13 beats.
  - response: all beats accepted, no strobe, cfg_err_cnt unchanged.
- Short command:
  - stimulus: lookup header, then 5 beats with last on beat 5.
  - response: no strobe, cfg_err_cnt = 1. A following valid key-offset command writes correctly.
- Reset mid-command:
  - stimulus: aresetn low after 10 action beats.
  - response: outputs 0 immediately, no action_en. After release, a fresh action command writes normally.
